// File: rtl/vblank_sched_pkg.sv
// vblank_sched_pkg
// Shared definitions for the vertical-blank update scheduler:
//   - sched_state_e        : scheduler FSM states
//   - N_REQ_DEF            : default number of game-logic requesters
//   - SLOT_CYCLES_DEF      : default maximum pclk cycles for one grant
//   - BLANK_CYCLES_800x600 : pclk cycles in one 800x600@60 blank window
//                            (28 blank lines x 1056 pclk per line)
package vblank_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_ACTIVE = 2'd0,
    WAIT_VBLANK = 2'd1,
    SCAN        = 2'd2,
    GRANT       = 2'd3
  } sched_state_e;

  localparam int N_REQ_DEF            = 4;
  localparam int SLOT_CYCLES_DEF      = 4096;
  localparam int BLANK_CYCLES_800x600 = 29568;

endpackage

// File: rtl/vblank_update_scheduler_rr_pick.sv
// rr_pick
// Combinational rotating-priority encoder. Returns the first set bit of
// cand, searching upward from index start and wrapping past N_REQ-1.
// Ports:
//   cand  [N_REQ-1:0] in  candidate mask (req & ~served)
//   start [ID_W-1:0]  in  index where the search begins (< N_REQ)
//   found             out at least one candidate bit is set
//   idx   [ID_W-1:0]  out index of the chosen candidate (0 when none)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot_s;
  logic [ID_W:0]    off_s;
  logic [ID_W:0]    sum_s;
  logic             found_s;
  logic [ID_W-1:0]  idx_s;

  // Rotate the candidates so the search start lands on bit 0.
  assign rot_s = N_REQ'({cand, cand} >> start);

  // Lowest set bit of the rotated mask, then map the offset back to an index.
  always_comb begin
    found_s = 1'b0;
    off_s   = {(ID_W+1){1'b0}};
    // Walk downward so the lowest offset is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found_s = 1'b1;
        off_s   = (ID_W+1)'(k);
      end else begin
        found_s = found_s;
        off_s   = off_s;
      end
    end
    sum_s = {1'b0, start} + off_s;
    if (sum_s >= (ID_W+1)'(N_REQ)) begin
      idx_s = ID_W'(sum_s - (ID_W+1)'(N_REQ));
    end else begin
      idx_s = ID_W'(sum_s);
    end
    if (!found_s) begin
      idx_s = {ID_W{1'b0}};
    end else begin
      idx_s = idx_s;
    end
  end

  assign found = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
// Round-robin arbiter sharing the game-state update port between N_REQ
// requesters. Grants are only issued inside the vertical blanking window so
// the visible frame never shows a half-applied update. Each requester is
// served at most once per window; the requester searched first rotates by
// one every frame.
// Optional feature macro: VBLANK_SCHED_FRAME_CNT_EN adds frame_cnt/ovr_cnt.
// Ports:
//   pclk         in   pixel clock
//   rst          in   synchronous active-high reset
//   vblnk        in   vertical blank level from the timing generator
//   req   [N]    in   per-requester request level
//   done  [N]    in   per-requester release (only looked at while granted)
//   gnt   [N]    out  one-hot registered grant
//   gnt_id[ID_W] out  index of the granted requester, 0 when none
//   window_open  out  scheduler is inside a blank window (SCAN or GRANT)
//   frame_tick   out  one-cycle pulse when a window opens
//   timeout      out  one-cycle pulse when a grant hits SLOT_CYCLES
//   overrun      out  one-cycle pulse when a grant is cut by vblnk falling
//   frame_cnt    out  (optional) wrapping count of frame_tick pulses
//   ovr_cnt      out  (optional) saturating count of timeout+overrun pulses
module vblank_update_scheduler
  import vblank_sched_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int SLOT_CYCLES = SLOT_CYCLES_DEF,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             window_open,
  output logic             frame_tick,
  output logic             timeout,
`ifdef VBLANK_SCHED_FRAME_CNT_EN
  output logic             overrun,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       ovr_cnt
`else
  output logic             overrun
`endif
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);

  sched_state_e     state_r, state_s;
  logic             vblnk_q_r;
  logic [N_REQ-1:0] served_r, served_s;
  logic [ID_W-1:0]  start_ptr_r, start_ptr_s;
  logic [ID_W-1:0]  search_r, search_s;
  logic [CNT_W-1:0] slot_cnt_r, slot_cnt_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [ID_W-1:0]  gnt_id_r, gnt_id_s;
  logic             window_open_r, window_open_s;
  logic             frame_tick_r, frame_tick_s;
  logic             timeout_r, timeout_s;
  logic             overrun_r, overrun_s;

  logic             rise_s;
  logic             release_s;
  logic             slot_end_s;
  logic [N_REQ-1:0] cand_s;
  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic [N_REQ-1:0] pick_onehot_s;

  // Index successor modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    if (i == ID_W'(N_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return i + ID_W'(1'b1);
    end
  endfunction

  assign rise_s        = vblnk & ~vblnk_q_r;
  assign cand_s        = req & ~served_r;
  assign release_s     = |(gnt_r & (done | ~req));
  assign slot_end_s    = (slot_cnt_r == CNT_W'(SLOT_CYCLES - 1));
  assign pick_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .cand  (cand_s),
    .start (search_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output logic for the scheduler.
  always_comb begin
    state_s       = state_r;
    served_s      = served_r;
    start_ptr_s   = start_ptr_r;
    search_s      = search_r;
    slot_cnt_s    = slot_cnt_r;
    gnt_s         = gnt_r;
    gnt_id_s      = gnt_id_r;
    window_open_s = window_open_r;
    frame_tick_s  = 1'b0;
    timeout_s     = 1'b0;
    overrun_s     = 1'b0;

    case (state_r)
      // A blank already in progress at reset is skipped entirely.
      WAIT_ACTIVE: begin
        if (!vblnk) begin
          state_s = WAIT_VBLANK;
        end else begin
          state_s = WAIT_ACTIVE;
        end
      end

      WAIT_VBLANK: begin
        if (rise_s) begin
          state_s       = SCAN;
          frame_tick_s  = 1'b1;
          window_open_s = 1'b1;
          served_s      = {N_REQ{1'b0}};
          search_s      = start_ptr_r;
          start_ptr_s   = next_idx(start_ptr_r);
        end else begin
          state_s = WAIT_VBLANK;
        end
      end

      // Idles here while the window lasts so late requests still get a slot.
      SCAN: begin
        if (!vblnk) begin
          state_s       = WAIT_VBLANK;
          window_open_s = 1'b0;
        end else if (pick_found_s) begin
          state_s    = GRANT;
          gnt_s      = pick_onehot_s;
          gnt_id_s   = pick_idx_s;
          served_s   = served_r | pick_onehot_s;
          slot_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = SCAN;
        end
      end

      // A voluntary release outranks both overrun and timeout.
      GRANT: begin
        slot_cnt_s = slot_cnt_r + CNT_W'(1'b1);
        if (release_s) begin
          gnt_s    = {N_REQ{1'b0}};
          gnt_id_s = {ID_W{1'b0}};
          search_s = next_idx(gnt_id_r);
          if (!vblnk) begin
            state_s       = WAIT_VBLANK;
            window_open_s = 1'b0;
          end else begin
            state_s = SCAN;
          end
        end else if (!vblnk) begin
          state_s       = WAIT_VBLANK;
          gnt_s         = {N_REQ{1'b0}};
          gnt_id_s      = {ID_W{1'b0}};
          overrun_s     = 1'b1;
          window_open_s = 1'b0;
        end else if (slot_end_s) begin
          state_s   = SCAN;
          gnt_s     = {N_REQ{1'b0}};
          gnt_id_s  = {ID_W{1'b0}};
          timeout_s = 1'b1;
          search_s  = next_idx(gnt_id_r);
        end else begin
          state_s = GRANT;
        end
      end

      default: begin
        state_s       = WAIT_ACTIVE;
        gnt_s         = {N_REQ{1'b0}};
        gnt_id_s      = {ID_W{1'b0}};
        window_open_s = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r       <= WAIT_ACTIVE;
      vblnk_q_r     <= 1'b0;
      served_r      <= {N_REQ{1'b0}};
      start_ptr_r   <= {ID_W{1'b0}};
      search_r      <= {ID_W{1'b0}};
      slot_cnt_r    <= {CNT_W{1'b0}};
      gnt_r         <= {N_REQ{1'b0}};
      gnt_id_r      <= {ID_W{1'b0}};
      window_open_r <= 1'b0;
      frame_tick_r  <= 1'b0;
      timeout_r     <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      vblnk_q_r     <= vblnk;
      served_r      <= served_s;
      start_ptr_r   <= start_ptr_s;
      search_r      <= search_s;
      slot_cnt_r    <= slot_cnt_s;
      gnt_r         <= gnt_s;
      gnt_id_r      <= gnt_id_s;
      window_open_r <= window_open_s;
      frame_tick_r  <= frame_tick_s;
      timeout_r     <= timeout_s;
      overrun_r     <= overrun_s;
    end
  end

  assign gnt         = gnt_r;
  assign gnt_id      = gnt_id_r;
  assign window_open = window_open_r;
  assign frame_tick  = frame_tick_r;
  assign timeout     = timeout_r;
  assign overrun     = overrun_r;

`ifdef VBLANK_SCHED_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;
  logic [7:0]  ovr_cnt_r;

  // Frame and revocation statistics, updated on the same edge as the pulses.
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
      ovr_cnt_r   <= 8'd0;
    end else begin
      if (frame_tick_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if ((timeout_s || overrun_s) && (ovr_cnt_r != 8'hFF)) begin
        ovr_cnt_r <= ovr_cnt_r + 8'd1;
      end else begin
        ovr_cnt_r <= ovr_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign ovr_cnt   = ovr_cnt_r;
`endif

endmodule
